// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package display_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SHOW} disp_state_t;

    localparam logic [7:0] BLANK_ALL = 8'hFF;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping,
// so the previous owner is chosen only when nobody else is requesting.
module rr_picker #(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         onehot,
    output logic [$clog2(N_REQ)-1:0] idx,
    output logic                     valid
);

    localparam int unsigned PW = $clog2(N_REQ);

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            for (int unsigned j = 0; j < N_REQ; j++) begin
                if (!valid && req[j] && (((32'(ptr) + i) % N_REQ) == j)) begin
                    valid     = 1'b1;
                    onehot[j] = 1'b1;
                    idx       = PW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Shares the 8-digit seven-segment scanner among N_REQ requesters with
// round-robin grant, a reload window per grant and min/max hold times.
module display_arbiter
    import display_pkg::*;
#(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned LOAD_CYCLES = 125000,
    parameter int unsigned MIN_HOLD    = 50000000,
    parameter int unsigned MAX_HOLD    = 200000000,
    parameter int unsigned CNT_W       = 28
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   value,
    input  logic [8*N_REQ-1:0]    blank,
    output logic [31:0]           number,
    output logic [7:0]            AN_ON,
    output logic                  reload,
    output logic [N_REQ-1:0]      grant,
    output logic                  active
);

    localparam int unsigned      PW        = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(MIN_HOLD);
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_HOLD);

    disp_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [PW-1:0]    rr_ptr;

    logic [N_REQ-1:0] pick_onehot;
    logic [PW-1:0]    pick_idx;
    logic             pick_valid;
    logic [31:0]      pick_value;
    logic [7:0]       pick_blank;
    logic             owner_req, rival_req, release_show, take;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_value = '0;
        pick_blank = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (pick_onehot[j]) begin
                pick_value = value[32*j +: 32];
                pick_blank = blank[8*j +: 8];
            end
        end
    end

    assign owner_req    = |(req & grant);
    assign rival_req    = |(req & ~grant);
    assign release_show = (state == SHOW) &&
                          ((!owner_req && cnt >= MIN_CNT) || (rival_req && cnt >= MAX_CNT));
    // A release with a waiting requester skips IDLE and reloads straight away.
    assign take         = pick_valid && (state == IDLE || release_show);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            number <= '0;
            AN_ON  <= BLANK_ALL;
            reload <= 1'b1;
            grant  <= '0;
            active <= 1'b0;
            rr_ptr <= PW'(N_REQ - 1);
            cnt    <= '0;
        end else if (take) begin
            state  <= LOAD;
            grant  <= pick_onehot;
            active <= 1'b1;
            rr_ptr <= pick_idx;
            number <= pick_value;
            AN_ON  <= pick_blank;
            reload <= 1'b1;
            cnt    <= '0;
        end else if (release_show) begin
            state  <= IDLE;
            grant  <= '0;
            active <= 1'b0;
            number <= '0;
            AN_ON  <= BLANK_ALL;
            reload <= 1'b1;
            cnt    <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (cnt == LOAD_LAST) begin
                        state  <= SHOW;
                        cnt    <= '0;
                        reload <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt < MAX_CNT)
                        cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter: an ownership/age model predicts every
// cycle's outputs; a negedge monitor compares them against the DUT.
module tb_display_arbiter;

    localparam int N    = 2;
    localparam int LC   = 4;
    localparam int MINH = 10;
    localparam int MAXH = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req = '0;
    logic [63:0] value = '0;
    logic [15:0] blank = '0;
    logic [31:0] number;
    logic [7:0]  AN_ON;
    logic        reload;
    logic [1:0]  grant;
    logic        active;

    display_arbiter #(
        .N_REQ       (N),
        .LOAD_CYCLES (LC),
        .MIN_HOLD    (MINH),
        .MAX_HOLD    (MAXH),
        .CNT_W       (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .value  (value),
        .blank  (blank),
        .number (number),
        .AN_ON  (AN_ON),
        .reload (reload),
        .grant  (grant),
        .active (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] number;
        logic [7:0]  an;
        logic        reload;
        logic [1:0]  grant;
        logic        active;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   running  = 1'b0;

    // Model: who owns the display and how many cycles since it was granted.
    int          m_owner = -1;
    int          m_age   = 0;
    int          m_rr    = N - 1;
    logic [31:0] m_num   = '0;
    logic [7:0]  m_an    = 8'hFF;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    always @(posedge clk) begin
        if (running) begin
            exp_t e;
            bit   rel;
            bit   rival;
            int   w;
            int   shown;
            if (!reset) begin
                m_owner = -1; m_age = 0; m_rr = N - 1; m_num = '0; m_an = 8'hFF;
            end else begin
                if (m_owner < 0) begin
                    rel = 1'b1;
                end else if (m_age < LC) begin
                    rel = 1'b0;
                end else begin
                    shown = m_age - LC;
                    rival = 1'b0;
                    for (int k = 0; k < N; k++)
                        if (k != m_owner && req[k]) rival = 1'b1;
                    rel = (!req[m_owner] && shown >= MINH) || (rival && shown >= MAXH);
                end
                if (rel) begin
                    w = -1;
                    for (int k = 1; k <= N; k++)
                        if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
                    if (w >= 0) begin
                        m_owner = w; m_rr = w; m_age = 0;
                        m_num = value[32*w +: 32];
                        m_an  = blank[8*w +: 8];
                    end else begin
                        m_owner = -1; m_age = 0; m_num = '0; m_an = 8'hFF;
                    end
                end else if (m_age < LC + MAXH) begin
                    m_age++;
                end
            end
            e.number = m_num;
            e.an     = m_an;
            e.grant  = (m_owner < 0) ? 2'b00 : 2'(1 << m_owner);
            e.active = (m_owner >= 0);
            e.reload = (m_owner < 0) || (m_age < LC);
            sb.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("number", number, e.number);
            check("AN_ON",  {24'h0, AN_ON}, {24'h0, e.an});
            check("reload", {31'h0, reload}, {31'h0, e.reload});
            check("grant",  {30'h0, grant}, {30'h0, e.grant});
            check("active", {31'h0, active}, {31'h0, e.active});
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        running = 1'b1;
        reset = 1'b0;
        cyc(3);
        check("rst_AN_ON",  {24'h0, AN_ON}, 32'hFF);
        check("rst_reload", {31'h0, reload}, 32'h1);
        check("rst_grant",  {30'h0, grant}, 32'h0);
        check("rst_number", number, 32'h0);
        reset = 1'b1;
        cyc(3);
        check("idle_grant", {30'h0, grant}, 32'h0);

        value[31:0] = 32'h1234_5678;
        blank[7:0]  = 8'hF0;
        req = 2'b01;
        cyc(1);
        check("g0_grant",  {30'h0, grant}, 32'h1);
        check("g0_number", number, 32'h1234_5678);
        check("g0_AN_ON",  {24'h0, AN_ON}, 32'hF0);
        value[31:0] = 32'hDEAD_BEEF;
        blank[7:0]  = 8'h0F;
        cyc(3);
        check("g0_reload_load", {31'h0, reload}, 32'h1);
        cyc(1);
        check("g0_reload_show", {31'h0, reload}, 32'h0);
        cyc(3);
        req = 2'b00;
        cyc(20);
        check("rel_idle_AN_ON", {24'h0, AN_ON}, 32'hFF);

        value = {32'hAAAA_1111, 32'h5555_0000};
        req = 2'b11;
        cyc(70);

        req = 2'b00;
        cyc(30);
        req = 2'b10;
        cyc(10);
        reset = 1'b0;
        cyc(1);
        check("midshow_rst_grant",  {30'h0, grant}, 32'h0);
        check("midshow_rst_reload", {31'h0, reload}, 32'h1);
        reset = 1'b1;
        cyc(10);

        for (int i = 0; i < 3000; i++) begin
            value = {$urandom, $urandom};
            blank = 16'($urandom);
            if ($urandom_range(0, 11) == 0) req = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 299) != 0);
            cyc(1);
        end

        reset = 1'b1;
        req = 2'b00;
        cyc(3);
        running = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
